// File: rtl/esop_cube_sequencer_pkg.sv
// Shared types and default sizing for the ESOP cube sequencer.
package esop_pkg;

    localparam int ESOP_NUM_VARS  = 50;
    localparam int ESOP_MAX_CUBES = 64;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    typedef struct packed {
        logic [ESOP_NUM_VARS-1:0] mask;
        logic [ESOP_NUM_VARS-1:0] pol;
    } cube_t;

endpackage

// File: rtl/esop_cube_sequencer_if.sv
// Vector-in / result-out handshake bundle for the ESOP cube sequencer.
interface esop_cube_sequencer_if
    import esop_pkg::*;
#(
    parameter int NUM_VARS = ESOP_NUM_VARS,
    parameter int CUBE_AW  = $clog2(ESOP_MAX_CUBES)
);
    logic                in_valid;
    logic                in_ready;
    logic [NUM_VARS-1:0] in_vec;
    logic                out_valid;
    logic                out_ready;
    logic                out_val;
    logic [CUBE_AW:0]    out_hits;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_val, out_hits
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_val, out_hits
    );
endinterface

// File: rtl/esop_cube_sequencer_match.sv
// Single-cube literal match: true when every literal present in the cube is satisfied.
module esop_cube_match
    import esop_pkg::*;
(
    input  logic [ESOP_NUM_VARS-1:0] vec,
    input  cube_t                    cube,
    output logic                     hit
);
    assign hit = &((vec ~^ cube.pol) | ~cube.mask);
endmodule

// File: rtl/esop_cube_sequencer.sv
// Time-multiplexed ESOP evaluator: one stored cube is matched per clock, parity and hit count returned.
module esop_cube_sequencer
    import esop_pkg::*;
#(
    parameter int NUM_VARS  = ESOP_NUM_VARS,
    parameter int MAX_CUBES = ESOP_MAX_CUBES,
    parameter int CUBE_AW   = $clog2(MAX_CUBES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [CUBE_AW-1:0]    cfg_addr,
    input  logic [NUM_VARS-1:0]   cfg_mask,
    input  logic [NUM_VARS-1:0]   cfg_pol,
    input  logic                  cfg_num_we,
    input  logic [CUBE_AW:0]      cfg_num,
    output logic                  cfg_err,
    esop_cube_sequencer_if.slave  io,
    output logic                  busy
);
    cube_t               cubes [MAX_CUBES];
    state_t              state;
    logic [CUBE_AW-1:0]  idx;
    logic [CUBE_AW:0]    num_cubes;
    logic [CUBE_AW:0]    hits;
    logic [CUBE_AW:0]    hits_n;
    logic [CUBE_AW:0]    num_eff;
    logic [NUM_VARS-1:0] in_vec_q;
    logic                acc;
    logic                acc_n;
    logic                empty_q;
    logic                hit_raw;
    logic                hit;
    logic                last;
    logic                idle;
    logic                addr_ok;
    logic                num_ok;
    logic                cube_wr;
    logic                num_wr;

    assign idle    = (state == IDLE);
    assign addr_ok = int'(cfg_addr) < MAX_CUBES;
    assign num_ok  = int'(cfg_num) <= MAX_CUBES;
    assign cube_wr = idle & cfg_we & addr_ok;
    assign num_wr  = idle & cfg_num_we & num_ok;
    // A count written in the accept cycle governs the vector accepted alongside it.
    assign num_eff = num_wr ? cfg_num : num_cubes;

    esop_cube_match u_match (
        .vec  (in_vec_q),
        .cube (cubes[idx]),
        .hit  (hit_raw)
    );

    // An empty cube set still spends one EVAL cycle (with the hit suppressed) so the
    // result latency is max(num_cubes,1) for every count.
    assign hit    = hit_raw & ~empty_q;
    assign acc_n  = acc ^ hit;
    assign hits_n = hits + (CUBE_AW+1)'(hit);
    assign last   = empty_q | ({1'b0, idx} == num_cubes - (CUBE_AW+1)'(1));

    always_ff @(posedge clk) begin
        if (cube_wr) begin
            cubes[cfg_addr] <= '{mask: cfg_mask, pol: cfg_pol};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            acc          <= 1'b0;
            hits         <= '0;
            empty_q      <= 1'b0;
            in_vec_q     <= '0;
            num_cubes    <= '0;
            cfg_err      <= 1'b0;
            busy         <= 1'b0;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
            io.out_val   <= 1'b0;
            io.out_hits  <= '0;
        end else begin
            cfg_err <= (~idle & (cfg_we | cfg_num_we))
                     | (idle & ((cfg_we & ~addr_ok) | (cfg_num_we & ~num_ok)));
            if (num_wr) begin
                num_cubes <= cfg_num;
            end
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        in_vec_q    <= io.in_vec;
                        idx         <= '0;
                        acc         <= 1'b0;
                        hits        <= '0;
                        empty_q     <= (num_eff == '0);
                        io.in_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= EVAL;
                    end
                end
                EVAL: begin
                    acc  <= acc_n;
                    hits <= hits_n;
                    idx  <= idx + CUBE_AW'(1);
                    if (last) begin
                        io.out_val   <= acc_n;
                        io.out_hits  <= hits_n;
                        io.out_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        io.in_ready  <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_esop_cube_sequencer.sv
// Directed and randomised checks of the ESOP cube sequencer against a reference XOR-of-ANDs model.
module tb_esop_cube_sequencer;
    localparam int NV = 50;
    localparam int MC = 64;
    localparam int AW = 6;

    logic          clk;
    logic          rst_n;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [NV-1:0] cfg_mask;
    logic [NV-1:0] cfg_pol;
    logic          cfg_num_we;
    logic [AW:0]   cfg_num;
    logic          cfg_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [NV-1:0] mask_m [MC];
    logic [NV-1:0] pol_m  [MC];

    esop_cube_sequencer_if #(.NUM_VARS(NV), .CUBE_AW(AW)) io ();

    esop_cube_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_mask   (cfg_mask),
        .cfg_pol    (cfg_pol),
        .cfg_num_we (cfg_num_we),
        .cfg_num    (cfg_num),
        .cfg_err    (cfg_err),
        .io         (io),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NV-1:0] rnd_vec();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[NV-1:0];
    endfunction

    function automatic logic [NV-1:0] bit_at(input int i);
        logic [NV-1:0] one;
        one = 1;
        return one << i;
    endfunction

    // Reference: a cube hits when no literal present in it disagrees with the vector.
    task automatic model(input logic [NV-1:0] vec, input int n, output logic val, output int hits);
        val = 1'b0;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            if (((vec ^ pol_m[i]) & mask_m[i]) == '0) begin
                hits++;
                val = ~val;
            end
        end
    endtask

    task automatic write_cube(input int addr, input logic [NV-1:0] m, input logic [NV-1:0] p);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = AW'(addr);
        cfg_mask = m;
        cfg_pol = p;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        mask_m[addr] = m;
        pol_m[addr] = p;
    endtask

    task automatic write_num(input int n);
        @(negedge clk);
        cfg_num_we = 1'b1;
        cfg_num = (AW+1)'(n);
        @(posedge clk);
        #1;
        cfg_num_we = 1'b0;
    endtask

    task automatic start_vector(input logic [NV-1:0] vec);
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_vec = vec;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", io.in_ready); end
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", io.out_valid); end
        checks++; if (io.out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b expected 0", io.out_val); end
        checks++; if (io.out_hits !== 7'd0) begin errors++; $display("FAIL reset_out_hits: got %0d expected 0", io.out_hits); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_two_cubes();
        logic [NV-1:0] vecs [3];
        logic          exp_val [3];
        int            exp_hits [3];
        int            lat;
        write_cube(0, bit_at(16), bit_at(16));
        write_cube(1, bit_at(48), '0);
        write_num(2);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL legal_cfg_err: got %b expected 0", cfg_err); end
        vecs[0] = bit_at(16);              exp_val[0] = 1'b0; exp_hits[0] = 2;
        vecs[1] = bit_at(16) | bit_at(48); exp_val[1] = 1'b1; exp_hits[1] = 1;
        vecs[2] = '0;                      exp_val[2] = 1'b1; exp_hits[2] = 1;
        for (int i = 0; i < 3; i++) begin
            start_vector(vecs[i]);
            wait_result(lat);
            checks++; if (lat != 2) begin errors++; $display("FAIL two_cube_latency[%0d]: got %0d expected 2", i, lat); end
            checks++; if (io.out_val !== exp_val[i]) begin errors++; $display("FAIL two_cube_val[%0d]: got %b expected %b", i, io.out_val, exp_val[i]); end
            checks++; if (io.out_hits !== 7'(exp_hits[i])) begin errors++; $display("FAIL two_cube_hits[%0d]: got %0d expected %0d", i, io.out_hits, exp_hits[i]); end
            ack();
        end
    endtask

    task automatic test_empty_and_const();
        int lat;
        write_num(0);
        start_vector(bit_at(16) | bit_at(3));
        wait_result(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL empty_latency: got %0d expected 1", lat); end
        checks++; if (io.out_val !== 1'b0) begin errors++; $display("FAIL empty_val: got %b expected 0", io.out_val); end
        checks++; if (io.out_hits !== 7'd0) begin errors++; $display("FAIL empty_hits: got %0d expected 0", io.out_hits); end
        ack();
        write_cube(0, '0, '0);
        write_num(1);
        start_vector('0);
        wait_result(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL const_latency: got %0d expected 1", lat); end
        checks++; if (io.out_val !== 1'b1) begin errors++; $display("FAIL const_val: got %b expected 1", io.out_val); end
        checks++; if (io.out_hits !== 7'd1) begin errors++; $display("FAIL const_hits: got %0d expected 1", io.out_hits); end
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        write_cube(0, bit_at(16), bit_at(16));
        write_num(2);
        start_vector(bit_at(16));
        wait_result(lat);
        for (int c = 0; c < 5; c++) begin
            checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, io.out_valid); end
            checks++; if (io.out_val !== 1'b0) begin errors++; $display("FAIL bp_val[%0d]: got %b expected 0", c, io.out_val); end
            checks++; if (io.out_hits !== 7'd2) begin errors++; $display("FAIL bp_hits[%0d]: got %0d expected 2", c, io.out_hits); end
            checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, io.in_ready); end
            @(posedge clk);
            #1;
        end
        ack();
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", io.out_valid); end
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", io.in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_cfg_err();
        int lat;
        start_vector(bit_at(16) | bit_at(48));
        cfg_we = 1'b1;
        cfg_addr = 6'd1;
        cfg_mask = '0;
        cfg_pol = '0;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL busy_write_err: got %b expected 1", cfg_err); end
        @(posedge clk);
        #1;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL busy_write_err_pulse: got %b expected 0", cfg_err); end
        checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL busy_write_valid: got %b expected 1", io.out_valid); end
        checks++; if (io.out_val !== 1'b1) begin errors++; $display("FAIL busy_write_val: got %b expected 1", io.out_val); end
        checks++; if (io.out_hits !== 7'd1) begin errors++; $display("FAIL busy_write_hits: got %0d expected 1", io.out_hits); end
        ack();
        start_vector(bit_at(16) | bit_at(48));
        wait_result(lat);
        checks++; if (io.out_hits !== 7'd1) begin errors++; $display("FAIL cube_unchanged_hits: got %0d expected 1", io.out_hits); end
        ack();
        @(negedge clk);
        cfg_num_we = 1'b1;
        cfg_num = 7'd65;
        @(posedge clk);
        #1;
        cfg_num_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL num_overflow_err: got %b expected 1", cfg_err); end
        start_vector(bit_at(16));
        wait_result(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL num_unchanged_latency: got %0d expected 2", lat); end
        checks++; if (io.out_hits !== 7'd2) begin errors++; $display("FAIL num_unchanged_hits: got %0d expected 2", io.out_hits); end
        ack();
    endtask

    task automatic test_cfg_same_cycle();
        int lat;
        @(negedge clk);
        cfg_num_we = 1'b1;
        cfg_num = 7'd1;
        io.in_valid = 1'b1;
        io.in_vec = bit_at(16);
        @(posedge clk);
        #1;
        cfg_num_we = 1'b0;
        io.in_valid = 1'b0;
        wait_result(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL same_cycle_latency: got %0d expected 1", lat); end
        checks++; if (io.out_val !== 1'b1) begin errors++; $display("FAIL same_cycle_val: got %b expected 1", io.out_val); end
        checks++; if (io.out_hits !== 7'd1) begin errors++; $display("FAIL same_cycle_hits: got %0d expected 1", io.out_hits); end
        ack();
    endtask

    task automatic test_random();
        logic [NV-1:0] v;
        logic          ev;
        int            eh;
        int            lat;
        for (int i = 0; i < MC; i++) begin
            write_cube(i, rnd_vec() & rnd_vec() & rnd_vec() & rnd_vec(), rnd_vec());
        end
        write_num(MC);
        for (int n = 0; n < 200; n++) begin
            v = rnd_vec();
            model(v, MC, ev, eh);
            start_vector(v);
            wait_result(lat);
            checks++; if (lat != MC) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, MC); end
            checks++; if (io.out_val !== ev) begin errors++; $display("FAIL rand_val[%0d]: got %b expected %b", n, io.out_val, ev); end
            checks++; if (io.out_hits !== 7'(eh)) begin errors++; $display("FAIL rand_hits[%0d]: got %0d expected %0d", n, io.out_hits, eh); end
            ack();
        end
    endtask

    task automatic test_reset_mid_eval();
        logic [NV-1:0] v;
        logic          ev;
        int            eh;
        int            lat;
        write_num(10);
        start_vector(rnd_vec());
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rst_eval_valid: got %b expected 0", io.out_valid); end
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL rst_eval_in_ready: got %b expected 1", io.in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_eval_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        start_vector(rnd_vec());
        wait_result(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL rst_num_cleared_latency: got %0d expected 1", lat); end
        checks++; if (io.out_hits !== 7'd0) begin errors++; $display("FAIL rst_num_cleared_hits: got %0d expected 0", io.out_hits); end
        ack();
        write_num(10);
        v = rnd_vec();
        model(v, 10, ev, eh);
        start_vector(v);
        wait_result(lat);
        checks++; if (lat != 10) begin errors++; $display("FAIL rst_reload_latency: got %0d expected 10", lat); end
        checks++; if (io.out_val !== ev) begin errors++; $display("FAIL rst_reload_val: got %b expected %b", io.out_val, ev); end
        checks++; if (io.out_hits !== 7'(eh)) begin errors++; $display("FAIL rst_reload_hits: got %0d expected %0d", io.out_hits, eh); end
        ack();
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_mask = '0;
        cfg_pol = '0;
        cfg_num_we = 1'b0;
        cfg_num = '0;
        io.in_valid = 1'b0;
        io.in_vec = '0;
        io.out_ready = 1'b0;
        test_reset();
        test_two_cubes();
        test_empty_and_const();
        test_backpressure();
        test_cfg_err();
        test_cfg_same_cycle();
        test_random();
        test_reset_mid_eval();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
